// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch queue between the instruction memory
// port and the decoder. Issues sequential word fetches (one outstanding at a
// time), buffers up to DEPTH returned words with their PCs and hands the
// oldest one to the decoder over a valid/ready handshake. A redirect flushes
// the queue, discards any in-flight response and restarts at the new PC.
//
// Build option: define FETCH_BUFFER_BYPASS_EN to forward a response straight
// to the decoder when the queue is empty (zero-cycle response latency).
// Without it every response is queued first (one-cycle latency) and there is
// no combinational path from mem_rdata to fetch_instr.

module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    input  logic        fetch_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Request tracking states.
    localparam logic [1:0] S_IDLE = 2'd0;  // nothing outstanding
    localparam logic [1:0] S_WAIT = 2'd1;  // one outstanding, keep its data
    localparam logic [1:0] S_DROP = 2'd2;  // one outstanding, discard its data

    logic [1:0]    state;
    logic [31:0]   fpc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];

    logic          queue_empty;
    logic          resp_keep;
    logic          resp_done;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic          issue;
    logic [31:0]   req_pc;

    // The two low redirect bits are ignored; the target is forced word-aligned.
    logic          redirect_pc_unused;
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // While in WAIT, fpc has already advanced past the outstanding request.
    assign req_pc      = fpc - 32'd4;
    assign queue_empty = (count == '0);

`ifdef FETCH_BUFFER_BYPASS_EN
    logic bypass_valid;
    assign bypass_valid = resp_keep & queue_empty;
`endif

    // Queue control and request issue decision for this cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // conditionals below can infer a latch.
        resp_keep   = (state == S_WAIT) && mem_ready && !redirect;
        resp_done   = ((state == S_WAIT) || (state == S_DROP)) && mem_ready;
        bypass_take = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        if (bypass_valid && fetch_ready) bypass_take = 1'b1;
`endif
        push       = resp_keep && !bypass_take;
        pop        = !queue_empty && fetch_ready && !redirect;
        count_next = count + CW'(push) - CW'(pop);
        issue      = 1'b0;
        if (!reset && !redirect && ((state == S_IDLE) || resp_done) &&
            (count_next < CW'(DEPTH)))
            issue = 1'b1;
    end

    assign mem_valid = issue;
    assign mem_instr = issue;
    assign mem_addr  = fpc;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign fetch_valid = !redirect && (!queue_empty || bypass_valid);
    assign fetch_pc    = bypass_valid ? req_pc    : pc_q[rd_ptr];
    assign fetch_instr = bypass_valid ? mem_rdata : instr_q[rd_ptr];
`else
    assign fetch_valid = !redirect && !queue_empty;
    assign fetch_pc    = pc_q[rd_ptr];
    assign fetch_instr = instr_q[rd_ptr];
`endif

    // Control state: reset, then redirect flush, then normal issue/queue update.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state  <= S_IDLE;
            fpc    <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fpc    <= {redirect_pc[31:2], 2'b00};
            if (((state == S_WAIT) || (state == S_DROP)) && !mem_ready)
                state <= S_DROP;
            else
                state <= S_IDLE;
        end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (issue) begin
                fpc   <= fpc + 32'd4;
                state <= S_WAIT;
            end else if (resp_done) begin
                state <= S_IDLE;
            end
        end
    end

    // Queue storage write on push.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; count and the pointers
        // alone decide which entries are meaningful.
        if (push && !reset) begin
            pc_q[wr_ptr]    <= req_pc;
            instr_q[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed tests for fetch_buffer. Stimulus pushes the
// expected memory requests and decoder-side words (with the cycle they must
// appear in) into scoreboard queues; independent monitor processes pop and
// compare whenever the DUT presents a request or a handshake completes.

module tb_fetch_buffer;

    localparam int DEPTH = 4;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_ready = 1'b0;

    always #5 clock = ~clock;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_ready (fetch_ready)
    );

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t exp_a[$];   // expected memory requests
    exp_t exp_f[$];   // expected decoder handshakes

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int pop_cnt = 0;
    int mem_lat = 1;

    // Memory contents: each word is its address with a fixed pattern mixed in.
    function automatic logic [31:0] instr_of(logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    function automatic void exp_req(logic [31:0] a, int c);
        exp_a.push_back('{pc: a, cyc: c});
    endfunction

    function automatic void exp_fetch(logic [31:0] a, int c);
        exp_f.push_back('{pc: a, cyc: c});
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle 0 is the first cycle with reset low.
    initial forever begin
        @(posedge clock);
        if (reset) cyc = 0;
        else       cyc++;
    end

    // Memory model: one response mem_lat cycles after each request.
    initial begin : memory_model
        logic        pend;
        logic        rst_s;
        int          cnt;
        logic [31:0] paddr;
        pend  = 1'b0;
        cnt   = 0;
        paddr = 32'h0;
        forever begin
            @(negedge clock);
            if (mem_valid && !reset) begin
                check("one_outstanding", {31'b0, pend}, 32'h0);
                pend  = 1'b1;
                cnt   = mem_lat;
                paddr = mem_addr;
            end
            @(posedge clock);
            rst_s = reset;
            #1;
            mem_ready = 1'b0;
            if (rst_s) begin
                pend = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = instr_of(paddr);
                    pend      = 1'b0;
                end
            end
        end
    end

    // Monitor: compares requests and completed handshakes with the scoreboards.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (mem_valid) begin
                    check("mem_instr", {31'b0, mem_instr}, 32'h1);
                    if (exp_a.size() > 0) begin
                        e = exp_a.pop_front();
                        check("req_addr", mem_addr, e.pc);
                        check("req_cycle", cyc, e.cyc);
                    end
                end
                if (redirect) check("valid_on_redirect", {31'b0, fetch_valid}, 32'h0);
                if (fetch_valid && fetch_ready && !redirect) begin
                    pop_cnt++;
                    if (exp_f.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_fetch: got pc 0x%08h, expected no handshake (cycle %0d)",
                                 fetch_pc, cyc);
                    end else begin
                        e = exp_f.pop_front();
                        check("fetch_pc", fetch_pc, e.pc);
                        check("fetch_instr", fetch_instr, instr_of(e.pc));
                        check("fetch_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic start_reset;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fetch_ready = 1'b0;
        tick;
        tick;
    endtask

    task automatic wait_cycle(int c);
        int n = 0;
        while (cyc < c && n < 1000) begin
            tick;
            n++;
        end
    endtask

    task automatic wait_pops(int target, int budget);
        int n = 0;
        while (pop_cnt < target && n < budget) begin
            tick;
            n++;
        end
        check("pop_budget", {31'b0, pop_cnt >= target}, 32'h1);
    endtask

    task automatic end_test;
        repeat (3) tick;
        check("fetch_sb_drained", exp_f.size(), 32'h0);
        check("req_sb_drained", exp_a.size(), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int target;

        // Reset values, then streaming with zero-wait memory.
        start_reset;
        @(negedge clock);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("rst_mem_instr", {31'b0, mem_instr}, 32'h0);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        tick;
        mem_lat = 1;
        for (int k = 0; k < 8; k++) begin
            exp_req(32'(4 * k), k);
            exp_fetch(32'(4 * k), 2 + k - BYP);
        end
        target      = pop_cnt + 8;
        fetch_ready = 1'b1;
        reset       = 1'b0;
        @(negedge clock);
        check("c0_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        wait_pops(target, 40);
        fetch_ready = 1'b0;
        end_test;

        // Queue fills to DEPTH with decoder stalled; release pops and issues together.
        start_reset;
        mem_lat = 1;
        exp_req(32'h0, 0);  exp_req(32'h4, 1);  exp_req(32'h8, 2);
        exp_req(32'hC, 3);  exp_req(32'h10, 10); exp_req(32'h14, 11);
        exp_fetch(32'h0, 10);  exp_fetch(32'h4, 11);  exp_fetch(32'h8, 12);
        exp_fetch(32'hC, 13);  exp_fetch(32'h10, 14); exp_fetch(32'h14, 15);
        reset = 1'b0;
        for (int c = 4; c < 10; c++) begin
            wait_cycle(c);
            @(negedge clock);
            check("full_no_issue", {31'b0, mem_valid}, 32'h0);
            check("full_valid", {31'b0, fetch_valid}, 32'h1);
        end
        wait_cycle(10);
        fetch_ready = 1'b1;
        target      = pop_cnt + 6;
        wait_pops(target, 30);
        fetch_ready = 1'b0;
        end_test;

        // Redirect while a request is outstanding on a 3-cycle memory.
        start_reset;
        mem_lat = 3;
        exp_req(32'h0, 0); exp_req(32'h4, 3); exp_req(32'h8, 6);
        exp_req(32'h100, 9); exp_req(32'h104, 12);
        exp_fetch(32'h100, 13 - BYP);
        reset = 1'b0;
        wait_cycle(7);
        @(negedge clock);
        check("pre_redirect_valid", {31'b0, fetch_valid}, 32'h1);
        check("pre_redirect_pc", fetch_pc, 32'h0);
        wait_cycle(8);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clock);
        check("redirect_no_issue", {31'b0, mem_valid}, 32'h0);
        wait_cycle(9);
        redirect    = 1'b0;
        fetch_ready = 1'b1;
        @(negedge clock);
        check("dropped_not_shown", {31'b0, fetch_valid}, 32'h0);
        target = pop_cnt + 1;
        wait_pops(target, 20);
        fetch_ready = 1'b0;
        end_test;

        // Redirect coincident with the response; unaligned target 0x103.
        start_reset;
        mem_lat = 1;
        exp_req(32'h0, 0); exp_req(32'h4, 1); exp_req(32'h100, 3); exp_req(32'h104, 4);
        exp_fetch(32'h100, 5 - BYP); exp_fetch(32'h104, 6 - BYP);
        reset = 1'b0;
        wait_cycle(2);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clock);
        check("coinc_no_issue", {31'b0, mem_valid}, 32'h0);
        wait_cycle(3);
        redirect    = 1'b0;
        fetch_ready = 1'b1;
        @(negedge clock);
        check("coinc_flushed", {31'b0, fetch_valid}, 32'h0);
        target = pop_cnt + 2;
        wait_pops(target, 20);
        fetch_ready = 1'b0;
        end_test;

        // Fetch address wraps from 0xFFFF_FFFC to 0x0.
        start_reset;
        mem_lat = 1;
        exp_req(32'hFFFF_FFFC, 1); exp_req(32'h0, 2); exp_req(32'h4, 3);
        exp_fetch(32'hFFFF_FFFC, 3 - BYP); exp_fetch(32'h0, 4 - BYP);
        fetch_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        reset       = 1'b0;
        @(negedge clock);
        check("wrap_redirect_no_issue", {31'b0, mem_valid}, 32'h0);
        wait_cycle(1);
        redirect = 1'b0;
        target   = pop_cnt + 2;
        wait_pops(target, 20);
        fetch_ready = 1'b0;
        end_test;

        // Reset with a request outstanding and two words queued.
        start_reset;
        mem_lat = 2;
        exp_req(32'h0, 0); exp_req(32'h4, 2); exp_req(32'h8, 4);
        reset = 1'b0;
        wait_cycle(4);
        @(negedge clock);
        check("mid_valid", {31'b0, fetch_valid}, 32'h1);
        check("mid_pc", fetch_pc, 32'h0);
        wait_cycle(5);
        reset = 1'b1;
        exp_req(32'h0, 0); exp_req(32'h4, 2);
        exp_fetch(32'h0, 3 - BYP);
        @(negedge clock);
        check("reset_no_issue", {31'b0, mem_valid}, 32'h0);
        tick;
        reset       = 1'b0;
        fetch_ready = 1'b1;
        @(negedge clock);
        check("post_reset_empty", {31'b0, fetch_valid}, 32'h0);
        target = pop_cnt + 1;
        wait_pops(target, 20);
        fetch_ready = 1'b0;
        end_test;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
